// File: rtl/d_fifo_flex.sv
// d_fifo_flex: parametrised valid/ready FIFO with occupancy count, full/empty and
// programmable almost-full/almost-empty flags, plus a synchronous flush.
// Latency: 1 cycle write-to-read (first-word-fall-through, empty queue never bypassed).
// Backpressure: io_din_r low when full, in reset or while flushing; it never looks at io_dout_r.
module d_fifo_flex #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 2,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] io_din,
    input  logic                  io_din_v,
    output logic                  io_din_r,
    output logic [DATA_WIDTH-1:0] io_dout,
    output logic                  io_dout_v,
    input  logic                  io_dout_r,
    input  logic                  io_flush,
    output logic [CW-1:0]         io_count,
    output logic                  io_full,
    output logic                  io_empty,
    output logic                  io_almost_full,
    output logic                  io_almost_empty
);

    // Pointers are exactly log2(depth) bits so they wrap modulo depth for free;
    // the count carries one extra bit so that "full" is distinguishable from "empty".
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    logic                  wr_fire;
    logic                  rd_fire;

    // Handshakes are decoded from registered count only. Gating both with flush
    // means a flush cycle moves no data; reset additionally holds off writers.
    // A full queue refuses writes even when a read is leaving the same cycle,
    // which keeps io_din_r free of any path from io_dout_r.
    assign io_din_r  = !reset && !io_flush && (count_q != DEPTH_C);
    assign io_dout_v = !io_flush && (count_q != '0);

    assign wr_fire   = io_din_v && io_din_r;
    assign rd_fire   = io_dout_v && io_dout_r;

    // Head of queue is shown only while valid; zeros otherwise so stale storage
    // (which flush/reset deliberately leave in place) never leaks downstream.
    assign io_dout   = io_dout_v ? mem_q[rd_ptr_q] : '0;

    // Status flags are plain decodes of the registered count, no hysteresis.
    assign io_count        = count_q;
    assign io_full         = (count_q == DEPTH_C);
    assign io_empty        = (count_q == '0);
    assign io_almost_full  = (count_q >= AF_C);
    assign io_almost_empty = (count_q <= AE_C);

    // Storage write; contents survive flush and reset by design.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= io_din;
        end
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset and flush both empty the queue at the next edge.
    always_ff @(posedge clock) begin
        if (reset || io_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_d_fifo_flex.sv
module tb_d_fifo_flex;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- DUT A: default parameters ----------------
    logic        rst_a, din_v_a, din_r_a, dout_v_a, dout_r_a, flush_a;
    logic [31:0] din_a, dout_a;
    logic [5:0]  count_a;
    logic        full_a, empty_a, af_a, ae_a;

    d_fifo_flex dut_a (
        .clock(clock), .reset(rst_a),
        .io_din(din_a), .io_din_v(din_v_a), .io_din_r(din_r_a),
        .io_dout(dout_a), .io_dout_v(dout_v_a), .io_dout_r(dout_r_a),
        .io_flush(flush_a), .io_count(count_a),
        .io_full(full_a), .io_empty(empty_a),
        .io_almost_full(af_a), .io_almost_empty(ae_a)
    );

    // ---------------- DUT B: 8 bit x 4 deep, AF=3, AE=0 ----------------
    logic        rst_b, din_v_b, din_r_b, dout_v_b, dout_r_b, flush_b;
    logic [7:0]  din_b, dout_b;
    logic [2:0]  count_b;
    logic        full_b, empty_b, af_b, ae_b;

    d_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(0)) dut_b (
        .clock(clock), .reset(rst_b),
        .io_din(din_b), .io_din_v(din_v_b), .io_din_r(din_r_b),
        .io_dout(dout_b), .io_dout_v(dout_v_b), .io_dout_r(dout_r_b),
        .io_flush(flush_b), .io_count(count_b),
        .io_full(full_b), .io_empty(empty_b),
        .io_almost_full(af_b), .io_almost_empty(ae_b)
    );

    // Scoreboards: a queue of words the FIFO is expected to hold, in order.
    logic [31:0] sb_a[$];
    logic [7:0]  sb_b[$];

    // Monitor A: compare DUT against the queue model mid-cycle, then advance
    // the model by what the coming edge must do.
    always @(negedge clock) begin : mon_a
        logic exp_dinr, exp_doutv;
        if (mon_en) begin
            exp_dinr  = !rst_a && !flush_a && (sb_a.size() != 32);
            exp_doutv = !flush_a && (sb_a.size() != 0);
            chk("a_count", 64'(count_a), 64'(sb_a.size()));
            chk("a_count_le_depth", 64'(count_a <= 6'd32), 64'd1);
            chk("a_full", 64'(full_a), 64'(sb_a.size() == 32));
            chk("a_empty", 64'(empty_a), 64'(sb_a.size() == 0));
            chk("a_almost_full", 64'(af_a), 64'(sb_a.size() >= 28));
            chk("a_almost_empty", 64'(ae_a), 64'(sb_a.size() <= 2));
            chk("a_din_r", 64'(din_r_a), 64'(exp_dinr));
            chk("a_dout_v", 64'(dout_v_a), 64'(exp_doutv));
            if (!exp_doutv) chk("a_dout_idle_zero", 64'(dout_a), 64'd0);
            else            chk("a_dout_head", 64'(dout_a), 64'(sb_a[0]));
            if (rst_a || flush_a) begin
                sb_a.delete();
            end else begin
                if (exp_doutv && dout_r_a) void'(sb_a.pop_front());
                if (exp_dinr && din_v_a)   sb_a.push_back(din_a);
            end
        end
    end

    // Monitor B: same rules with the small-configuration thresholds.
    always @(negedge clock) begin : mon_b
        logic exp_dinr, exp_doutv;
        if (mon_en) begin
            exp_dinr  = !rst_b && !flush_b && (sb_b.size() != 4);
            exp_doutv = !flush_b && (sb_b.size() != 0);
            chk("b_count", 64'(count_b), 64'(sb_b.size()));
            chk("b_count_le_depth", 64'(count_b <= 3'd4), 64'd1);
            chk("b_full", 64'(full_b), 64'(sb_b.size() == 4));
            chk("b_empty", 64'(empty_b), 64'(sb_b.size() == 0));
            chk("b_almost_full", 64'(af_b), 64'(sb_b.size() >= 3));
            chk("b_almost_empty", 64'(ae_b), 64'(sb_b.size() == 0));
            chk("b_din_r", 64'(din_r_b), 64'(exp_dinr));
            chk("b_dout_v", 64'(dout_v_b), 64'(exp_doutv));
            if (!exp_doutv) chk("b_dout_idle_zero", 64'(dout_b), 64'd0);
            else            chk("b_dout_head", 64'(dout_b), 64'(sb_b[0]));
            if (rst_b || flush_b) begin
                sb_b.delete();
            end else begin
                if (exp_doutv && dout_r_b) void'(sb_b.pop_front());
                if (exp_dinr && din_v_b)   sb_b.push_back(din_b);
            end
        end
    end

    task automatic step_a(input logic v, input logic [31:0] d, input logic r,
                          input logic f, input logic rs);
        din_v_a = v; din_a = d; dout_r_a = r; flush_a = f; rst_a = rs;
        @(posedge clock); #1;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d, input logic r,
                          input logic f, input logic rs);
        din_v_b = v; din_b = d; dout_r_b = r; flush_b = f; rst_b = rs;
        @(posedge clock); #1;
    endtask

    initial begin
        rst_a = 1'b1; din_v_a = 1'b0; din_a = '0; dout_r_a = 1'b0; flush_a = 1'b0;
        rst_b = 1'b1; din_v_b = 1'b0; din_b = '0; dout_r_b = 1'b0; flush_b = 1'b0;
        @(posedge clock); #1;
        mon_en = 1'b1;
        step_a(0, 0, 0, 0, 1);
        step_b(0, 0, 0, 0, 1);

        fork
            begin : seq_a
                // Fill 0x1..0x20 with reads held off, plus one refused 33rd write.
                for (int i = 1; i <= 33; i++) step_a(1, 32'(i), 0, 0, 0);
                // Drain in order, one per cycle, and one extra cycle at empty.
                for (int i = 0; i < 33; i++) step_a(0, 0, 1, 0, 0);
                // Single word latency, then fill to full watching almost-full.
                step_a(1, 32'hDEADBEEF, 0, 0, 0);
                step_a(0, 0, 0, 0, 0);
                for (int i = 0; i < 31; i++) step_a(1, 32'h100 + 32'(i), 0, 0, 0);
                // Full with simultaneous read: read only, then the write lands.
                step_a(1, 32'hA0, 1, 0, 0);
                step_a(1, 32'hA1, 0, 0, 0);
                // Drain to occupancy 5, then stream across many pointer wraps.
                for (int i = 0; i < 27; i++) step_a(0, 0, 1, 0, 0);
                for (int i = 0; i < 100; i++) step_a(1, 32'h1000 + 32'(i), 1, 0, 0);
                // Raise to 10 and flush mid-stream.
                for (int i = 0; i < 5; i++) step_a(1, 32'h2000 + 32'(i), 0, 0, 0);
                step_a(1, 32'h77, 1, 1, 0);
                step_a(1, 32'h55, 0, 0, 0);
                step_a(0, 0, 1, 0, 0);
                // Randomised traffic with occasional flush and reset.
                for (int i = 0; i < 3000; i++) begin
                    int bias;
                    bias = (i / 500) % 3;
                    step_a(($urandom_range(0, 3) >= 32'(bias)),
                           $urandom(),
                           ($urandom_range(0, 3) >= 32'(2 - bias)),
                           ($urandom_range(0, 63) == 0),
                           ($urandom_range(0, 127) == 0));
                end
                for (int i = 0; i < 40; i++) step_a(0, 0, 1, 0, 0);
            end
            begin : seq_b
                // Thresholds: almost-full at 3, full at 4, almost-empty only at 0.
                for (int i = 1; i <= 5; i++) step_b(1, 8'(i), 0, 0, 0);
                step_b(0, 0, 1, 0, 0);
                step_b(0, 0, 1, 0, 0);
                // Reset at count 2 with a writer waiting; held for two cycles.
                step_b(1, 8'hC1, 0, 0, 1);
                step_b(1, 8'hC2, 0, 0, 1);
                step_b(1, 8'hC3, 0, 0, 0);
                step_b(0, 0, 1, 0, 0);
                for (int i = 0; i < 1500; i++) begin
                    step_b(($urandom_range(0, 1) == 1), 8'($urandom()),
                           ($urandom_range(0, 2) != 0),
                           ($urandom_range(0, 47) == 0),
                           ($urandom_range(0, 95) == 0));
                end
                for (int i = 0; i < 8; i++) step_b(0, 0, 1, 0, 0);
            end
        join

        @(posedge clock); #1;
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
